// File: rtl/nat_pkg.sv
// -----------------------------------------------------------------------------
// nat_pkg
//   Shared types and default widths for the NAT lookup path.
//   TUPLE_W    : default lookup key width (5-tuple + pad)
//   CONN_W     : default connection-id / result width
//   port_id_t  : requester identity carried in the tag FIFO
//   arb_state_t: issue FSM states of hash_lookup_arbiter
// -----------------------------------------------------------------------------
package nat_pkg;

    localparam int TUPLE_W = 128;
    localparam int CONN_W  = 16;

    typedef enum logic {
        PORT_TX = 1'b0,
        PORT_RX = 1'b1
    } port_id_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/hash_lookup_arbiter_tag_fifo.sv
// -----------------------------------------------------------------------------
// hash_arb_tag_fifo
//   DEPTH x 1-bit synchronous FIFO holding the source port of every lookup in
//   flight in the engine. Push and pop may occur in the same cycle, including
//   when full. A pop while empty is ignored, and a push while full is accepted
//   only together with a pop.
// Ports
//   clk, reset        : clock, asynchronous active-low reset
//   push, push_data   : enqueue a port id
//   pop               : dequeue the head entry
//   rd_data           : head entry (valid while !empty)
//   full, empty, count: occupancy status
// -----------------------------------------------------------------------------
module hash_arb_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  nat_pkg::port_id_t        push_data,
    input  logic                     pop,
    output nat_pkg::port_id_t        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    import nat_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    port_id_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/hash_lookup_arbiter.sv
// -----------------------------------------------------------------------------
// hash_lookup_arbiter
//   Shares one hash/connection-table lookup engine between the NAT tx (port 0)
//   and rx (port 1) packet processors. Each requester's one-cycle tuple pulse
//   is captured in a pending register, pending requests are granted
//   round-robin, and every issued lookup is tagged with its source so the
//   in-order engine responses can be steered back as one-cycle conn pulses.
// Ports
//   clk, reset                  : clock, asynchronous active-low reset
//   tuple_data_x/tuple_valid_x  : request key + pulse from requester x
//   conn_data_x/conn_valid_x    : result + pulse to requester x
//   eng_tuple/eng_valid/eng_ready : request channel to the engine
//   eng_conn/eng_resp_valid     : in-order result channel from the engine
//   ovf[1:0]                    : sticky, request dropped on port x
//   orphan                      : sticky, response arrived with no tag
// Optional build macro HASH_ARB_STATS_EN adds grant_cnt_0/1, stall_cnt and
// inflight observation outputs.
// -----------------------------------------------------------------------------
module hash_lookup_arbiter #(
    parameter int TUPLE_W = nat_pkg::TUPLE_W,
    parameter int CONN_W  = nat_pkg::CONN_W,
    parameter int MAX_OUT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [TUPLE_W-1:0]   tuple_data_0,
    input  logic                 tuple_valid_0,
    output logic [CONN_W-1:0]    conn_data_0,
    output logic                 conn_valid_0,
    input  logic [TUPLE_W-1:0]   tuple_data_1,
    input  logic                 tuple_valid_1,
    output logic [CONN_W-1:0]    conn_data_1,
    output logic                 conn_valid_1,
    output logic [TUPLE_W-1:0]   eng_tuple,
    output logic                 eng_valid,
    input  logic                 eng_ready,
    input  logic [CONN_W-1:0]    eng_conn,
    input  logic                 eng_resp_valid,
    output logic [1:0]           ovf,
    output logic                 orphan
`ifdef HASH_ARB_STATS_EN
    ,
    output logic [31:0]              grant_cnt_0,
    output logic [31:0]              grant_cnt_1,
    output logic [31:0]              stall_cnt,
    output logic [$clog2(MAX_OUT):0] inflight
`endif
);
    import nat_pkg::*;

    localparam int CNT_W = $clog2(MAX_OUT) + 1;

    arb_state_t          state, state_nxt;
    port_id_t            cur_port;
    port_id_t            last_grant;
    port_id_t            sel;
    logic                load;

    logic [TUPLE_W-1:0]  pend_data_0, pend_data_1;
    logic                pend_vld_0,  pend_vld_1;

    logic                hs;
    logic                clr_0, clr_1;

    port_id_t            tag_head;
    logic                tag_full, tag_empty;
    logic [CNT_W-1:0]    tag_count;
    logic                pop_eff;
    logic                room_after_hs;

    assign hs      = eng_valid && eng_ready;
    assign clr_0   = hs && (cur_port == PORT_TX);
    assign clr_1   = hs && (cur_port == PORT_RX);
    assign pop_eff = eng_resp_valid && !tag_empty;

    // Occupancy once this cycle's handshake push and response pop land.
    assign room_after_hs = (int'(tag_count) + 1 - int'(pop_eff)) < MAX_OUT;

    hash_arb_tag_fifo #(.DEPTH(MAX_OUT)) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (hs),
        .push_data (cur_port),
        .pop       (eng_resp_valid),
        .rd_data   (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    // ---- capture stage: one pending slot per requester ----
    // A pulse arriving while the slot is still occupied is lost unless the
    // slot is being handed to the engine on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_vld_0 <= 1'b0;
            pend_vld_1 <= 1'b0;
            ovf        <= 2'b00;
        end else begin
            if (tuple_valid_0) begin
                if (pend_vld_0 && !clr_0) ovf[0] <= 1'b1;
                else                      pend_vld_0 <= 1'b1;
            end else if (clr_0) begin
                pend_vld_0 <= 1'b0;
            end

            if (tuple_valid_1) begin
                if (pend_vld_1 && !clr_1) ovf[1] <= 1'b1;
                else                      pend_vld_1 <= 1'b1;
            end else if (clr_1) begin
                pend_vld_1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (tuple_valid_0 && !(pend_vld_0 && !clr_0)) pend_data_0 <= tuple_data_0;
        if (tuple_valid_1 && !(pend_vld_1 && !clr_1)) pend_data_1 <= tuple_data_1;
    end

    // ---- issue stage: round-robin select and engine request register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ARB_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        sel       = PORT_TX;
        case (state)
            ARB_IDLE: begin
                if ((pend_vld_0 || pend_vld_1) && !tag_full) begin
                    state_nxt = ARB_ISSUE;
                    load      = 1'b1;
                    if (pend_vld_0 && pend_vld_1)
                        sel = (last_grant == PORT_TX) ? PORT_RX : PORT_TX;
                    else if (pend_vld_1)
                        sel = PORT_RX;
                    else
                        sel = PORT_TX;
                end
            end
            ARB_ISSUE: begin
                if (hs) begin
                    // Back-to-back issue only ever goes to the other port,
                    // which is also the round-robin winner after this grant.
                    if (cur_port == PORT_TX && pend_vld_1 && room_after_hs) begin
                        load = 1'b1;
                        sel  = PORT_RX;
                    end else if (cur_port == PORT_RX && pend_vld_0 && room_after_hs) begin
                        load = 1'b1;
                        sel  = PORT_TX;
                    end else begin
                        state_nxt = ARB_IDLE;
                    end
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eng_valid  <= 1'b0;
            eng_tuple  <= '0;
            cur_port   <= PORT_TX;
            last_grant <= PORT_RX;
        end else begin
            if (load) begin
                eng_valid <= 1'b1;
                eng_tuple <= (sel == PORT_TX) ? pend_data_0 : pend_data_1;
                cur_port  <= sel;
            end else if (hs) begin
                eng_valid <= 1'b0;
            end
            if (hs) last_grant <= cur_port;
        end
    end

    // ---- response stage: steer result to the tagged requester ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            conn_valid_0 <= 1'b0;
            conn_valid_1 <= 1'b0;
            conn_data_0  <= '0;
            conn_data_1  <= '0;
            orphan       <= 1'b0;
        end else begin
            conn_valid_0 <= 1'b0;
            conn_valid_1 <= 1'b0;
            if (eng_resp_valid) begin
                if (tag_empty) begin
                    orphan <= 1'b1;
                end else if (tag_head == PORT_TX) begin
                    conn_valid_0 <= 1'b1;
                    conn_data_0  <= eng_conn;
                end else begin
                    conn_valid_1 <= 1'b1;
                    conn_data_1  <= eng_conn;
                end
            end
        end
    end

`ifdef HASH_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_cnt_0 <= '0;
            grant_cnt_1 <= '0;
            stall_cnt   <= '0;
        end else begin
            if (clr_0) grant_cnt_0 <= grant_cnt_0 + 32'd1;
            if (clr_1) grant_cnt_1 <= grant_cnt_1 + 32'd1;
            if (eng_valid && !eng_ready) stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign inflight = tag_count;
`endif

endmodule

// File: tb/tb_hash_lookup_arbiter.sv
module tb_hash_lookup_arbiter;

    localparam int TW = 128;
    localparam int CW = 16;
    localparam int MO = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [TW-1:0]   tuple_data_0 = '0, tuple_data_1 = '0;
    logic            tuple_valid_0 = 1'b0, tuple_valid_1 = 1'b0;
    logic [CW-1:0]   conn_data_0, conn_data_1;
    logic            conn_valid_0, conn_valid_1;
    logic [TW-1:0]   eng_tuple;
    logic            eng_valid;
    logic            eng_ready = 1'b0;
    logic [CW-1:0]   eng_conn = '0;
    logic            eng_resp_valid = 1'b0;
    logic [1:0]      ovf;
    logic            orphan;
`ifdef HASH_ARB_STATS_EN
    logic [31:0]             grant_cnt_0, grant_cnt_1, stall_cnt;
    logic [$clog2(MO):0]     inflight;
`endif

    hash_lookup_arbiter #(.TUPLE_W(TW), .CONN_W(CW), .MAX_OUT(MO)) dut (
        .clk            (clk),
        .reset          (reset),
        .tuple_data_0   (tuple_data_0),
        .tuple_valid_0  (tuple_valid_0),
        .conn_data_0    (conn_data_0),
        .conn_valid_0   (conn_valid_0),
        .tuple_data_1   (tuple_data_1),
        .tuple_valid_1  (tuple_valid_1),
        .conn_data_1    (conn_data_1),
        .conn_valid_1   (conn_valid_1),
        .eng_tuple      (eng_tuple),
        .eng_valid      (eng_valid),
        .eng_ready      (eng_ready),
        .eng_conn       (eng_conn),
        .eng_resp_valid (eng_resp_valid),
        .ovf            (ovf),
        .orphan         (orphan)
`ifdef HASH_ARB_STATS_EN
        ,
        .grant_cnt_0    (grant_cnt_0),
        .grant_cnt_1    (grant_cnt_1),
        .stall_cnt      (stall_cnt),
        .inflight       (inflight)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int rcv0 = 0, rcv1 = 0;
    logic [CW-1:0] q0[$];
    logic [CW-1:0] q1[$];
    logic [CW-1:0] eq[$];

    // Engine result for a key: a fixed fold of the 128-bit tuple.
    function automatic logic [CW-1:0] ref_hash(input logic [TW-1:0] k);
        logic [CW-1:0] r;
        r = 16'h5a5a;
        for (int i = 0; i < TW/CW; i++) r = r ^ k[CW*i +: CW] ^ CW'(i);
        return r;
    endfunction

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every conn pulse must match the head of its port queue.
    initial begin
        logic [CW-1:0] e;
        forever begin
            @(negedge clk);
            if (conn_valid_0 && conn_valid_1) begin
                checks++; errors++;
                $display("FAIL both_conn_valid: got 1 on both ports expected at most one");
            end
            if (conn_valid_0) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL conn0_unexpected: got %0h expected no pulse", conn_data_0);
                end else begin
                    e = q0.pop_front();
                    if (conn_data_0 !== e) begin
                        errors++;
                        $display("FAIL conn0_data: got %0h expected %0h", conn_data_0, e);
                    end
                end
                rcv0++;
            end
            if (conn_valid_1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL conn1_unexpected: got %0h expected no pulse", conn_data_1);
                end else begin
                    e = q1.pop_front();
                    if (conn_data_1 !== e) begin
                        errors++;
                        $display("FAIL conn1_data: got %0h expected %0h", conn_data_1, e);
                    end
                end
                rcv1++;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        tuple_valid_0 = 1'b0; tuple_valid_1 = 1'b0;
        eng_resp_valid = 1'b0; eng_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic respond(input logic [CW-1:0] v);
        eng_resp_valid = 1'b1; eng_conn = v;
        @(negedge clk);
        eng_resp_valid = 1'b0;
    endtask

    initial begin
        logic [TW-1:0] ka, kb, kc, kd, ke;
        int sent0, sent1, wait_cnt;
        bit found;

        ka = {32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5};
        kb = {32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F, 32'hDEADBEEF};
        kc = {32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
        kd = {32'hCAFEF00D, 32'h0BADC0DE, 32'h12345678, 32'h9ABCDEF0};
        ke = {32'hFEEDFACE, 32'h00000001, 32'h80000000, 32'h7FFFFFFF};

        // ---- reset state ----
        do_reset();
        chk("rst_eng_valid", eng_valid, 0);
        chk("rst_eng_tuple", eng_tuple, 0);
        chk("rst_conn_valid", {conn_valid_1, conn_valid_0}, 0);
        chk("rst_conn_data", {conn_data_1, conn_data_0}, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_orphan", orphan, 0);

        // ---- single tx, minimum latency ----
        eng_ready = 1'b1;
        tuple_data_0 = ka; tuple_valid_0 = 1'b1;
        @(negedge clk); tuple_valid_0 = 1'b0;
        chk("single_not_yet", eng_valid, 0);
        @(negedge clk);
        chk("single_eng_valid", eng_valid, 1);
        chk("single_eng_tuple", eng_tuple, ka);
        @(negedge clk);
        chk("single_idle_after_hs", eng_valid, 0);
        q0.push_back(16'h0042);
        respond(16'h0042);
        chk("single_conn_valid0", conn_valid_0, 1);
        chk("single_conn_valid1", conn_valid_1, 0);
        @(negedge clk);
        chk("single_hold", {conn_valid_0, conn_data_0}, {1'b0, 16'h0042});

        // ---- simultaneous requests: tx then rx ----
        do_reset();
        eng_ready = 1'b1;
        tuple_data_0 = kb; tuple_data_1 = kc;
        tuple_valid_0 = 1'b1; tuple_valid_1 = 1'b1;
        @(negedge clk); tuple_valid_0 = 1'b0; tuple_valid_1 = 1'b0;
        @(negedge clk);
        chk("simul_first_tx", {eng_valid, eng_tuple}, {1'b1, kb});
        @(negedge clk);
        chk("simul_second_rx", {eng_valid, eng_tuple}, {1'b1, kc});
        @(negedge clk);
        chk("simul_idle", eng_valid, 0);
        q0.push_back(16'h0011); q1.push_back(16'h0022);
        respond(16'h0011);
        respond(16'h0022);
        @(negedge clk);
        chk("simul_data", {conn_data_0, conn_data_1}, {16'h0011, 16'h0022});

        // ---- backpressure and overflow ----
        do_reset();
        eng_ready = 1'b0;
        tuple_data_0 = kd; tuple_valid_0 = 1'b1;
        @(negedge clk); tuple_valid_0 = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("stall_stable", {eng_valid, eng_tuple}, {1'b1, kd});
            if (i == 1) begin tuple_data_0 = ke; tuple_valid_0 = 1'b1; end
            if (i == 2) tuple_valid_0 = 1'b0;
            @(negedge clk);
        end
        chk("stall_ovf", ovf, 2'b01);
        eng_ready = 1'b1;
        @(negedge clk);
        chk("stall_dropped", eng_valid, 0);
        q0.push_back(16'h0033);
        respond(16'h0033);
        @(negedge clk);
        chk("stall_no_more", eng_valid, 0);

        // ---- tag FIFO full ----
        do_reset();
        eng_ready = 1'b1;
        tuple_data_0 = ka; tuple_data_1 = kb;
        tuple_valid_0 = 1'b1; tuple_valid_1 = 1'b1;
        @(negedge clk); tuple_valid_0 = 1'b0; tuple_valid_1 = 1'b0;
        repeat (3) @(negedge clk);
        tuple_data_0 = kc; tuple_data_1 = kd;
        tuple_valid_0 = 1'b1; tuple_valid_1 = 1'b1;
        @(negedge clk); tuple_valid_0 = 1'b0; tuple_valid_1 = 1'b0;
        repeat (3) @(negedge clk);
        tuple_data_0 = ke; tuple_valid_0 = 1'b1;
        @(negedge clk); tuple_valid_0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("full_no_issue", eng_valid, 0);
            @(negedge clk);
        end
        q0.push_back(16'h0101);
        respond(16'h0101);
        chk("full_not_same_edge", eng_valid, 0);
        @(negedge clk);
        chk("full_fifth_issue", {eng_valid, eng_tuple}, {1'b1, ke});
        @(negedge clk);
        chk("full_fifth_hs", eng_valid, 0);
        q1.push_back(16'h0202); q0.push_back(16'h0303);
        q1.push_back(16'h0404); q0.push_back(16'h0505);
        respond(16'h0202); respond(16'h0303);
        respond(16'h0404); respond(16'h0505);
        repeat (2) @(negedge clk);
        chk("full_ovf_clear", ovf, 0);

        // ---- orphan ----
        chk("orphan_before", orphan, 0);
        respond(16'hBEEF);
        @(negedge clk);
        chk("orphan_set", orphan, 1);

        // ---- asynchronous reset during ISSUE ----
        do_reset();
        chk("orphan_cleared", orphan, 0);
        eng_ready = 1'b0;
        tuple_data_1 = kc; tuple_valid_1 = 1'b1;
        @(negedge clk); tuple_valid_1 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (eng_valid) found = 1'b1;
        end
        chk("areset_reach_issue", found, 1);
        #2 reset = 1'b0;
        #1;
        chk("areset_eng_valid", eng_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
`ifdef HASH_ARB_STATS_EN
        chk("areset_stats", {grant_cnt_0, grant_cnt_1, stall_cnt, 29'd0, inflight}, '0);
`endif
        respond(16'h7777);
        @(negedge clk);
        chk("areset_orphan", orphan, 1);

        // ---- randomized traffic against the scoreboard ----
        do_reset();
        sent0 = 0; sent1 = 0; rcv0 = 0; rcv1 = 0;
        eq.delete();
        for (int cyc = 0; cyc < 3000 || (cyc < 3600 && (q0.size() + q1.size() + eq.size()) != 0); cyc++) begin
            logic [TW-1:0] k;
            tuple_valid_0 = 1'b0; tuple_valid_1 = 1'b0;
            if (cyc < 3000 && sent0 == rcv0 && ($urandom % 3) == 0) begin
                k = {$urandom, $urandom, $urandom, $urandom};
                tuple_data_0 = k; tuple_valid_0 = 1'b1;
                q0.push_back(ref_hash(k)); sent0++;
            end
            if (cyc < 3000 && sent1 == rcv1 && ($urandom % 3) == 0) begin
                k = {$urandom, $urandom, $urandom, $urandom};
                tuple_data_1 = k; tuple_valid_1 = 1'b1;
                q1.push_back(ref_hash(k)); sent1++;
            end
            // Engine: answer earlier accepted lookups in order, then accept.
            eng_resp_valid = 1'b0;
            if (eq.size() != 0 && ($urandom % 2) == 0) begin
                eng_resp_valid = 1'b1;
                eng_conn = eq.pop_front();
            end
            eng_ready = (($urandom % 3) != 0);
            if (eng_valid && eng_ready) eq.push_back(ref_hash(eng_tuple));
            @(negedge clk);
        end
        tuple_valid_0 = 1'b0; tuple_valid_1 = 1'b0;
        eng_resp_valid = 1'b0; eng_ready = 1'b0;
        wait_cnt = 0;
        while ((rcv0 != sent0 || rcv1 != sent1) && wait_cnt < 50) begin
            @(negedge clk); wait_cnt++;
        end
        chk("rand_drained", {q0.size(), q1.size()}, 0);
        chk("rand_rcv_count", {rcv0, rcv1}, {sent0, sent1});
        chk("rand_flags", {ovf, orphan, eng_valid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
